// File: rtl/uart_receiver_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART receiver slice: the receive FSM state
// encoding, the frame data width and a byte type used by the output
// interface.
// ---------------------------------------------------------------------------
package uart_pkg;

    // Number of data bits carried in one frame (LSB transmitted first).
    localparam int DATA_BITS = 8;

    typedef logic [DATA_BITS-1:0] rx_byte_t;

    // Receive FSM states, in the order a frame is walked through.
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_IDLE = 3'd4
    } rx_state_t;

endpackage

// File: rtl/uart_receiver_if.sv
// ---------------------------------------------------------------------------
// uart_receiver_if
// Valid/ready byte stream leaving the UART receiver.
//   data_out       : received byte, meaningful only while data_out_valid=1
//   data_out_valid : a byte is waiting for the consumer
//   data_out_ready : consumer takes the byte on a clock edge where both are 1
// Modports:
//   master : the receiver side (drives data and valid)
//   slave  : the consumer side (drives ready)
// ---------------------------------------------------------------------------
interface uart_receiver_if;
    import uart_pkg::*;

    rx_byte_t data_out;
    logic     data_out_valid;
    logic     data_out_ready;

    modport master (
        output data_out,
        output data_out_valid,
        input  data_out_ready
    );

    modport slave (
        input  data_out,
        input  data_out_valid,
        output data_out_ready
    );

endinterface

// File: rtl/uart_receiver_sync2.sv
// ---------------------------------------------------------------------------
// sync2
// Two-flop synchronizer for a single asynchronous bit.
// Ports:
//   clk : destination clock
//   rst : asynchronous active-low reset, loads RESET_VALUE into both flops
//   d   : asynchronous input
//   q   : synchronized output
// ---------------------------------------------------------------------------
module sync2 #(
    parameter logic RESET_VALUE = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    // Both stages share the reset value so an idle-high line does not look
    // like a falling edge when reset is released.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta <= RESET_VALUE;
            q    <= RESET_VALUE;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_receiver.sv
// ---------------------------------------------------------------------------
// uart_receiver
// 8N1 UART receiver with a single-entry valid/ready output register.
// Parameters:
//   CLOCK_FREQ : clk frequency in Hz
//   BAUD_RATE  : line bit rate in bits/s
// Ports:
//   clk       : single clock, rising edge
//   rst       : asynchronous active-low reset
//   serial_in : asynchronous UART line, idle high
//   rx_if     : byte output stream (data_out / data_out_valid / data_out_ready)
//   frame_err : one-cycle pulse when a stop bit is sampled low
//   overrun   : one-cycle pulse when a finished byte is dropped because the
//               output register still holds an unaccepted byte
// ---------------------------------------------------------------------------
module uart_receiver
    import uart_pkg::*;
#(
    parameter int CLOCK_FREQ = 50_000_000,
    parameter int BAUD_RATE  = 115200
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   serial_in,
    uart_receiver_if.master        rx_if,
    output logic                   frame_err,
    output logic                   overrun
);

    localparam int SYMBOL_EDGE_TIME = CLOCK_FREQ / BAUD_RATE;
    localparam int SAMPLE_TIME      = SYMBOL_EDGE_TIME / 2;
    localparam int CNT_W = (SYMBOL_EDGE_TIME > 1) ? $clog2(SYMBOL_EDGE_TIME) : 1;

    localparam logic [CNT_W-1:0] SYMBOL_LAST = CNT_W'(SYMBOL_EDGE_TIME - 1);
    localparam logic [CNT_W-1:0] SAMPLE_LAST = CNT_W'(SAMPLE_TIME - 1);
    localparam logic [2:0]       LAST_BIT    = 3'(DATA_BITS - 1);

    logic       line;
    rx_state_t  state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [2:0] bit_idx, bit_idx_next;
    rx_byte_t   shift_reg, shift_next;
    logic       byte_done, done_next;
    logic       ferr_next;

    sync2 #(.RESET_VALUE(1'b1)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (serial_in),
        .q   (line)
    );

    // Frame-tracking registers. byte_done is a registered strobe so the
    // output stage sees a finished byte one cycle after the stop sample.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
            byte_done <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            bit_idx   <= bit_idx_next;
            shift_reg <= shift_next;
            byte_done <= done_next;
            frame_err <= ferr_next;
        end
    end

    // Next-state logic. The start bit is re-checked half a symbol after the
    // falling edge; from then on every sample lands one full symbol later,
    // i.e. in the middle of each data bit and of the stop bit.
    always_comb begin
        state_next   = state;
        cnt_next     = cnt;
        bit_idx_next = bit_idx;
        shift_next   = shift_reg;
        done_next    = 1'b0;
        ferr_next    = 1'b0;
        case (state)
            IDLE: begin
                if (!line) begin
                    state_next = START;
                    cnt_next   = '0;
                end
            end
            START: begin
                if (cnt == SAMPLE_LAST) begin
                    if (!line) begin
                        state_next   = DATA;
                        cnt_next     = '0;
                        bit_idx_next = '0;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            DATA: begin
                if (cnt == SYMBOL_LAST) begin
                    shift_next = {line, shift_reg[DATA_BITS-1:1]};
                    cnt_next   = '0;
                    if (bit_idx == LAST_BIT) begin
                        state_next = STOP;
                    end else begin
                        bit_idx_next = bit_idx + 3'd1;
                    end
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            STOP: begin
                if (cnt == SYMBOL_LAST) begin
                    cnt_next = '0;
                    if (line) begin
                        done_next  = 1'b1;
                        state_next = IDLE;
                    end else begin
                        ferr_next  = 1'b1;
                        state_next = WAIT_IDLE;
                    end
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            WAIT_IDLE: begin
                if (line) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Output register. A finished byte is accepted only if the register is
    // empty or being emptied on this same edge; otherwise the new byte is
    // dropped and the held one is kept intact.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_if.data_out       <= '0;
            rx_if.data_out_valid <= 1'b0;
            overrun              <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (byte_done) begin
                if (!rx_if.data_out_valid || rx_if.data_out_ready) begin
                    rx_if.data_out       <= shift_reg;
                    rx_if.data_out_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (rx_if.data_out_valid && rx_if.data_out_ready) begin
                rx_if.data_out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_receiver.sv
// ---------------------------------------------------------------------------
// tb_uart_receiver
// Self-checking bench for uart_receiver at the default 50 MHz / 115200 baud.
// Frames are driven bit by bit at exactly one symbol per bit; a monitor
// records every accepted byte and every pulse so the directed steps can
// compare what was seen against what the frame rules predict.
// ---------------------------------------------------------------------------
module tb_uart_receiver;
    import uart_pkg::*;

    localparam int CLOCK_FREQ = 50_000_000;
    localparam int BAUD_RATE  = 115200;
    localparam int BIT_CYCLES = CLOCK_FREQ / BAUD_RATE;
    localparam int HALF_BIT   = BIT_CYCLES / 2;
    localparam int LATENCY    = 2 + HALF_BIT + 9 * BIT_CYCLES + 1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic serial_in = 1'b1;
    logic frame_err;
    logic overrun;

    uart_receiver_if rx_if ();

    uart_receiver #(
        .CLOCK_FREQ (CLOCK_FREQ),
        .BAUD_RATE  (BAUD_RATE)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .serial_in (serial_in),
        .rx_if     (rx_if),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    int vectors     = 0;
    int miscompares = 0;

    int cyc = 0;
    int start_edge = 0;
    int rise_cnt = 0;
    int rise_cyc = 0;
    int ferr_cnt = 0;
    int ovr_cnt = 0;
    int cur_width = 0;
    int last_width = 0;
    int hold_viol = 0;
    logic valid_prev = 1'b0;
    logic [7:0] data_prev = 8'h00;
    logic [7:0] rx_log[$];

    // 100 MHz-style clock; the absolute period is irrelevant to the design.
    always #5 clk = ~clk;

    // Edge counter used to time the output against the start edge.
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor on the falling edge: logs accepted bytes, counts pulse cycles,
    // measures valid high time and flags data changing while valid is held.
    always @(negedge clk) begin
        if (rx_if.data_out_valid && rx_if.data_out_ready) rx_log.push_back(rx_if.data_out);
        if (frame_err) ferr_cnt++;
        if (overrun) ovr_cnt++;
        if (rx_if.data_out_valid) begin
            if (!valid_prev) begin
                rise_cnt++;
                rise_cyc  = cyc;
                cur_width = 0;
            end else if (rx_if.data_out !== data_prev) begin
                hold_viol++;
            end
            cur_width++;
        end else if (valid_prev) begin
            last_width = cur_width;
        end
        valid_prev = rx_if.data_out_valid;
        data_prev  = rx_if.data_out;
    end

    // Hard time limit so a stuck receiver can never hang the run.
    initial begin
        #(95_000 * 10);
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic holdBit();
        repeat (BIT_CYCLES) @(posedge clk);
        #1;
    endtask

    // Drives one complete frame: start bit, 8 data bits LSB first, then the
    // given stop bit value, which is left on the line afterwards.
    task automatic applyStimulus(input logic [7:0] data, input logic stop_bit);
        @(posedge clk);
        #1;
        serial_in  = 1'b0;
        start_edge = cyc + 1;
        holdBit();
        for (int i = 0; i < 8; i++) begin
            serial_in = data[i];
            holdBit();
        end
        serial_in = stop_bit;
        holdBit();
    endtask

    task automatic waitForValid(input string tag, input int prev_rises);
        for (int i = 0; i < 2 * BIT_CYCLES && rise_cnt <= prev_rises; i++) @(negedge clk);
        checkOutput(tag, 32'(rise_cnt > prev_rises), 32'd1);
    endtask

    function automatic logic [31:0] logAt(input int idx);
        if (idx < rx_log.size()) return 32'(rx_log[idx]);
        return 32'hDEAD_BEEF;
    endfunction

    initial begin
        int r0, n0, f0, o0, h0, bad_frames;
        logic [7:0] exp_q[$];
        logic [7:0] partial;
        logic [7:0] rnd;
        logic good;

        rx_if.data_out_ready = 1'b1;
        serial_in = 1'b1;
        rst = 1'b0;
        repeat (5) @(negedge clk);
        checkOutput("reset data_out", 32'(rx_if.data_out), 32'h00);
        checkOutput("reset valid", 32'(rx_if.data_out_valid), 32'd0);
        checkOutput("reset frame_err", 32'(frame_err), 32'd0);
        checkOutput("reset overrun", 32'(overrun), 32'd0);
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (10) @(posedge clk);

        // Single frame, consumer always ready.
        $display("[TB] frame 0x55 with ready high");
        r0 = rise_cnt; n0 = rx_log.size();
        applyStimulus(8'h55, 1'b1);
        waitForValid("t1 valid rise", r0);
        checkOutput("t1 latency", 32'(rise_cyc - start_edge), 32'(LATENCY));
        repeat (10) @(negedge clk);
        checkOutput("t1 data", logAt(n0), 32'h55);
        checkOutput("t1 valid width", 32'(last_width), 32'd1);

        // Back-pressure: byte must be held until ready rises.
        $display("[TB] frame 0xA3 with delayed ready");
        rx_if.data_out_ready = 1'b0;
        r0 = rise_cnt; n0 = rx_log.size(); h0 = hold_viol;
        applyStimulus(8'hA3, 1'b1);
        waitForValid("t2 valid rise", r0);
        repeat (2000) @(posedge clk);
        #1;
        checkOutput("t2 held valid", 32'(rx_if.data_out_valid), 32'd1);
        checkOutput("t2 held data", 32'(rx_if.data_out), 32'hA3);
        rx_if.data_out_ready = 1'b1;
        @(negedge clk);
        checkOutput("t2 valid before accept", 32'(rx_if.data_out_valid), 32'd1);
        @(negedge clk);
        checkOutput("t2 valid after accept", 32'(rx_if.data_out_valid), 32'd0);
        checkOutput("t2 hold stable", 32'(hold_viol - h0), 32'd0);
        checkOutput("t2 data", logAt(n0), 32'hA3);
        checkOutput("t2 count", 32'(rx_log.size() - n0), 32'd1);

        // Short low pulse is not a start bit.
        $display("[TB] 100-cycle glitch");
        r0 = rise_cnt; f0 = ferr_cnt;
        @(posedge clk);
        #1 serial_in = 1'b0;
        repeat (100) @(posedge clk);
        #1 serial_in = 1'b1;
        repeat (2 * BIT_CYCLES) @(posedge clk);
        checkOutput("t3 no valid", 32'(rise_cnt - r0), 32'd0);
        checkOutput("t3 no frame_err", 32'(ferr_cnt - f0), 32'd0);

        // Broken stop bit, long break, then a clean copy of the same byte.
        $display("[TB] framing error then recovery");
        r0 = rise_cnt; n0 = rx_log.size(); f0 = ferr_cnt;
        applyStimulus(8'h3C, 1'b0);
        repeat (1000) @(posedge clk);
        #1 serial_in = 1'b1;
        holdBit();
        checkOutput("t4 frame_err pulse", 32'(ferr_cnt - f0), 32'd1);
        checkOutput("t4 no valid on error", 32'(rise_cnt - r0), 32'd0);
        applyStimulus(8'h3C, 1'b1);
        waitForValid("t4 valid rise", r0);
        repeat (10) @(negedge clk);
        checkOutput("t4 data", logAt(n0), 32'h3C);
        checkOutput("t4 single valid", 32'(rise_cnt - r0), 32'd1);
        checkOutput("t4 single frame_err", 32'(ferr_cnt - f0), 32'd1);

        // Two back-to-back frames against a stalled consumer.
        $display("[TB] back-to-back 0x11 0x22 with ready low");
        rx_if.data_out_ready = 1'b0;
        r0 = rise_cnt; n0 = rx_log.size(); o0 = ovr_cnt;
        applyStimulus(8'h11, 1'b1);
        applyStimulus(8'h22, 1'b1);
        holdBit();
        checkOutput("t5 overrun pulse", 32'(ovr_cnt - o0), 32'd1);
        checkOutput("t5 held data", 32'(rx_if.data_out), 32'h11);
        checkOutput("t5 held valid", 32'(rx_if.data_out_valid), 32'd1);
        rx_if.data_out_ready = 1'b1;
        repeat (5) @(negedge clk);
        checkOutput("t5 data", logAt(n0), 32'h11);
        checkOutput("t5 count", 32'(rx_log.size() - n0), 32'd1);
        checkOutput("t5 rises", 32'(rise_cnt - r0), 32'd1);

        // Reset in the middle of bit 4 of 0x7E.
        $display("[TB] reset mid-frame");
        partial = 8'h7E;
        @(posedge clk);
        #1 serial_in = 1'b0;
        holdBit();
        for (int i = 0; i < 4; i++) begin
            serial_in = partial[i];
            holdBit();
        end
        serial_in = partial[4];
        repeat (HALF_BIT) @(posedge clk);
        #1 rst = 1'b0;
        serial_in = 1'b1;
        #1;
        checkOutput("t6 reset data_out", 32'(rx_if.data_out), 32'h00);
        checkOutput("t6 reset valid", 32'(rx_if.data_out_valid), 32'd0);
        checkOutput("t6 reset frame_err", 32'(frame_err), 32'd0);
        checkOutput("t6 reset overrun", 32'(overrun), 32'd0);
        repeat (20) @(posedge clk);
        #1 rst = 1'b1;
        holdBit();
        r0 = rise_cnt; n0 = rx_log.size();
        applyStimulus(8'h81, 1'b1);
        waitForValid("t6 valid rise", r0);
        repeat (10) @(negedge clk);
        checkOutput("t6 data", logAt(n0), 32'h81);
        checkOutput("t6 count", 32'(rx_log.size() - n0), 32'd1);

        // Random frames; a good stop bit delivers the byte, a bad one only
        // produces a framing error.
        $display("[TB] random frames");
        n0 = rx_log.size(); f0 = ferr_cnt; bad_frames = 0;
        for (int k = 0; k < 6; k++) begin
            rnd  = 8'($urandom_range(0, 255));
            good = ($urandom_range(0, 3) != 0);
            r0   = rise_cnt;
            applyStimulus(rnd, good);
            if (good) begin
                exp_q.push_back(rnd);
                waitForValid("rand valid rise", r0);
                checkOutput("rand latency", 32'(rise_cyc - start_edge), 32'(LATENCY));
            end else begin
                bad_frames++;
                repeat (50) @(posedge clk);
                #1 serial_in = 1'b1;
                holdBit();
            end
        end
        repeat (10) @(negedge clk);
        checkOutput("rand count", 32'(rx_log.size() - n0), 32'(exp_q.size()));
        for (int k = 0; k < exp_q.size(); k++) begin
            checkOutput("rand data", logAt(n0 + k), 32'(exp_q[k]));
        end
        checkOutput("rand frame_err", 32'(ferr_cnt - f0), 32'(bad_frames));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
